output_writer: RTL and testbench
================================

OUTPUT_WRITER -- requirements
Module: output_writer

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per scan slot (1 kHz slot at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port wr_en  input  1  write request from CPU MMIO side.
REQ-005 SHALL have port wr_addr  input  2  register select: 0=LED, 1=DISP value, 2=CTRL, 3=reserved.
REQ-006 SHALL have port wr_data  input  32  write data.
REQ-007 SHALL have port wr_ready  output  1  high when a write can be accepted.
REQ-008 SHALL have port light  output  8  LED drive, active-high.
REQ-009 SHALL have port tub_ctrl  output  8  digit enables, one per tube, active-high; bit 7 leftmost.
REQ-010 SHALL have port seg_ctrl1  output  8  segments for digits 7..4, bits 7..0 = a,b,c,d,e,f,g,dp, active-high.
REQ-011 SHALL have port seg_ctrl2  output  8  segments for digits 3..0, same encoding.

Function
REQ-012 SHALL accept a write only in a cycle with wr_en=1 and wr_ready=1; wr_en while wr_ready=0 is ignored, not queued.
REQ-013 SHALL, on accepted write to addr 0, load light <= wr_data[7:0], visible next cycle; wr_ready stays 1.
REQ-014 SHALL, on accepted write to addr 2, load CTRL (bit0 = display enable, bits 15:8 = blank mask, bit n blanks digit n), effective next cycle; wr_ready stays 1.
REQ-015 SHALL, on accepted write to addr 1, load a 32-bit shadow register, set pending, and drive wr_ready=0 from next cycle.
REQ-016 SHALL copy shadow into the active DISP register at the frame boundary (prescaler = SCAN_DIV-1 and scan index = 3), clear pending the same edge, and return wr_ready=1 the following cycle; worst-case latency 4*SCAN_DIV+1 cycles.
REQ-017 SHALL treat writes to addr 3 as accepted no-ops.
REQ-018 SHALL run a prescaler 0..SCAN_DIV-1 continuously; at terminal count the 2-bit scan index k advances 0->1->2->3->0.
REQ-019 SHALL, in slot k, assert tub_ctrl bits k and k+4 only; seg_ctrl1 = decode(DISP[4(k+4)+3:4(k+4)]), seg_ctrl2 = decode(DISP[4k+3:4k]).
REQ-020 SHALL decode hex 0-F to the standard 7-segment glyphs (A,b,C,d,E,F for 10-15), dp always 0; e.g. 0 -> 8'hFC, 8 -> 8'hFE, F -> 8'h8E.
REQ-021 SHALL, for a blanked digit, force its tub_ctrl bit and its segment bus to 0 in its slot.
REQ-022 SHALL, with enable=0, force tub_ctrl, seg_ctrl1, seg_ctrl2 to 0 while prescaler, scan index and pending commit keep running.
REQ-023 SHALL register tub_ctrl/seg outputs (one-cycle latency from slot change), never showing two slots' values in one cycle.

Reset
REQ-024 SHALL, while rst=0, asynchronously clear light, DISP, shadow, pending, prescaler, scan index, blank mask; set enable=1 and wr_ready=1.
REQ-025 SHALL, after reset release, drive tub_ctrl=8'h11, seg_ctrl1=seg_ctrl2=8'hFC; a reset during pending discards the shadow value.

Structure
REQ-026 SHALL place address constants, CTRL bit positions, reset values and the 16-entry glyph table in shared package output_writer_pkg.
REQ-027 SHALL implement decoding in sub-module seg_decoder (4-bit in, 8-bit out, combinational), instantiated twice.

Verification (SCAN_DIV=4)
REQ-028 SHALL check: reset release -> tub_ctrl=8'h11, segs 8'hFC, light=0, wr_ready=1.
REQ-029 SHALL check: write addr0 data 8'hA5 -> light=8'hA5 next cycle, wr_ready never drops.
REQ-030 SHALL check: write addr1 32'h8765_4321 mid-frame -> wr_ready=0 until frame boundary, then slot 0 shows tub 8'h11, seg_ctrl1=decode(5), seg_ctrl2=decode(1); slot 3 shows tub 8'h88, decode(8)/decode(4).
REQ-031 SHALL check: wr_en held while wr_ready=0 with addr0 8'hFF -> light unchanged.
REQ-032 SHALL check: CTRL = 32'h0000_0101 (digit 0 blanked) -> slot 0 tub 8'h10, seg_ctrl2=0; CTRL=0 -> all display outputs 0 while pending commit still completes.
REQ-033 SHALL check: rst asserted while pending -> wr_ready=1, DISP=0 after release.

Source files
------------

// File: rtl/output_writer_pkg.sv
// Shared constants for the MMIO output writer: register map, CTRL layout,
// reset values and the 7-segment glyph table.
package output_writer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SLOT_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_LED  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_DISP = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd3;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_BLANK_LSB = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] blank;
    logic              en;
  } ctrl_t;

  localparam ctrl_t             CTRL_RST  = '{blank: 8'h00, en: 1'b1};
  localparam logic [BYTE_W-1:0] LIGHT_RST = 8'h00;
  localparam logic [DATA_W-1:0] DISP_RST  = 32'h0000_0000;
  localparam logic [BYTE_W-1:0] TUB_RST   = 8'h11;

  // Bits 7..0 = a,b,c,d,e,f,g,dp; entry 0 is the rightmost element.
  localparam logic [15:0][BYTE_W-1:0] GLYPH_TABLE = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  localparam logic [BYTE_W-1:0] SEG_RST = GLYPH_TABLE[0];

endpackage

// File: rtl/output_writer_seg_decoder.sv
// Combinational hex nibble to 7-segment glyph lookup (dp always off).
module seg_decoder
  import output_writer_pkg::*;
(
  input  logic [NIB_W-1:0]  digit_i,
  output logic [BYTE_W-1:0] seg_o
);

  assign seg_o = GLYPH_TABLE[digit_i];

endmodule

// File: rtl/output_writer.sv
// MMIO output writer: LED latch, CTRL register and a 4-slot multiplexed
// 8-digit 7-segment driver with frame-synchronous DISP updates.
module output_writer
  import output_writer_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [BYTE_W-1:0] light,
  output logic [BYTE_W-1:0] tub_ctrl,
  output logic [BYTE_W-1:0] seg_ctrl1,
  output logic [BYTE_W-1:0] seg_ctrl2
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SLOT_W-1:0]  scan_q, scan_d;
  logic [DATA_W-1:0]  disp_q, disp_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [BYTE_W-1:0]  light_q, light_d;
  logic               ready_q, ready_d;
  logic [BYTE_W-1:0]  tub_q, tub_d;
  logic [BYTE_W-1:0]  seg1_q, seg1_d;
  logic [BYTE_W-1:0]  seg2_q, seg2_d;

  logic               slot_end_c;
  logic               frame_end_c;
  logic               accept_c;
  logic [4:0]         lo_idx_c;
  logic [4:0]         hi_idx_c;
  logic [NIB_W-1:0]   lo_nib_c;
  logic [NIB_W-1:0]   hi_nib_c;
  logic [BYTE_W-1:0]  lo_glyph_c;
  logic [BYTE_W-1:0]  hi_glyph_c;
  logic [3:0]         slot_oh_c;
  logic               blank_lo_c;
  logic               blank_hi_c;

  assign slot_end_c  = (presc_q == PRESC_MAX);
  assign frame_end_c = slot_end_c && (scan_q == 2'd3);
  assign accept_c    = wr_en && ready_q;

  // Scan timebase, register file and shadow-to-active commit.
  always_comb begin
    presc_d  = presc_q;
    scan_d   = scan_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    light_d  = light_q;
    ready_d  = ready_q;

    if (slot_end_c) begin
      presc_d = '0;
      scan_d  = scan_q + 2'd1;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end

    // A pending value only lands between frames so no frame mixes two values.
    if (frame_end_c && !ready_q) begin
      disp_d  = shadow_q;
      ready_d = 1'b1;
    end

    if (accept_c) begin
      case (wr_addr)
        ADDR_LED:  light_d = wr_data[BYTE_W-1:0];
        ADDR_DISP: begin
          shadow_d = wr_data;
          ready_d  = 1'b0;
        end
        ADDR_CTRL: ctrl_d = '{blank: wr_data[CTRL_BLANK_LSB +: BYTE_W],
                              en:    wr_data[CTRL_EN_BIT]};
        ADDR_RSVD: ;
        default:   ;
      endcase
    end
  end

  // Slot k drives digit k on the low bus and digit k+4 on the high bus.
  assign lo_idx_c   = {1'b0, scan_q, 2'b00};
  assign hi_idx_c   = {1'b1, scan_q, 2'b00};
  assign lo_nib_c   = disp_q[lo_idx_c +: NIB_W];
  assign hi_nib_c   = disp_q[hi_idx_c +: NIB_W];
  assign slot_oh_c  = 4'b0001 << scan_q;
  assign blank_lo_c = ctrl_q.blank[{1'b0, scan_q}];
  assign blank_hi_c = ctrl_q.blank[{1'b1, scan_q}];

  seg_decoder u_dec_hi (
    .digit_i (hi_nib_c),
    .seg_o   (hi_glyph_c)
  );

  seg_decoder u_dec_lo (
    .digit_i (lo_nib_c),
    .seg_o   (lo_glyph_c)
  );

  always_comb begin
    tub_d  = '0;
    seg1_d = '0;
    seg2_d = '0;
    if (ctrl_q.en) begin
      if (!blank_hi_c) begin
        tub_d[7:4] = slot_oh_c;
        seg1_d     = hi_glyph_c;
      end
      if (!blank_lo_c) begin
        tub_d[3:0] = slot_oh_c;
        seg2_d     = lo_glyph_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      scan_q   <= '0;
      disp_q   <= DISP_RST;
      shadow_q <= DISP_RST;
      ctrl_q   <= CTRL_RST;
      light_q  <= LIGHT_RST;
      ready_q  <= 1'b1;
      tub_q    <= TUB_RST;
      seg1_q   <= SEG_RST;
      seg2_q   <= SEG_RST;
    end else begin
      presc_q  <= presc_d;
      scan_q   <= scan_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
      light_q  <= light_d;
      ready_q  <= ready_d;
      tub_q    <= tub_d;
      seg1_q   <= seg1_d;
      seg2_q   <= seg2_d;
    end
  end

  assign wr_ready  = ready_q;
  assign light     = light_q;
  assign tub_ctrl  = tub_q;
  assign seg_ctrl1 = seg1_q;
  assign seg_ctrl2 = seg2_q;

endmodule

// File: tb/tb_output_writer.sv
// Directed bench for output_writer with SCAN_DIV=4 (16-cycle frames).
module tb_output_writer;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [7:0]  light;
  logic [7:0]  tub_ctrl;
  logic [7:0]  seg_ctrl1;
  logic [7:0]  seg_ctrl2;

  int checks = 0;
  int errors = 0;
  int n;

  output_writer #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .light     (light),
    .tub_ctrl  (tub_ctrl),
    .seg_ctrl1 (seg_ctrl1),
    .seg_ctrl2 (seg_ctrl2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [7:0] tub, input logic [7:0] s1,
                          input logic [7:0] s2);
    chk({tag, "_tub"},  32'(tub_ctrl),  32'(tub));
    chk({tag, "_seg1"}, 32'(seg_ctrl1), 32'(s1));
    chk({tag, "_seg2"}, 32'(seg_ctrl2), 32'(s2));
  endtask

  task automatic wait_ready(input int bound, output int cnt);
    cnt = 0;
    while (wr_ready !== 1'b1 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_tub(input string tag, input logic [7:0] exp, input int bound);
    int cnt;
    cnt = 0;
    while (tub_ctrl !== exp && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_sync"}, 32'(tub_ctrl), 32'(exp));
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("in_reset_ready", 32'(wr_ready), 32'd1);
    chk("in_reset_tub", 32'(tub_ctrl), 32'h11);

    rst = 1'b1;
    @(negedge clk);
    chk_disp("after_reset", 8'h11, 8'hFC, 8'hFC);
    chk("after_reset_light", 32'(light), 32'h00);
    chk("after_reset_ready", 32'(wr_ready), 32'd1);

    // LED write
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h0000_00A5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("led_light", 32'(light), 32'hA5);
    chk("led_ready", 32'(wr_ready), 32'd1);

    // Reserved address is a no-op
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rsvd_light", 32'(light), 32'hA5);
    chk("rsvd_ready", 32'(wr_ready), 32'd1);

    // DISP write, then hold an LED write while not ready
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h8765_4321;
    @(negedge clk);
    wr_addr = 2'd0; wr_data = 32'h0000_00FF;
    chk("disp_ready_low", 32'(wr_ready), 32'd0);
    chk_disp("disp_old_value", tub_ctrl, 8'hFC, 8'hFC);
    wait_ready(40, n);
    wr_en = 1'b0;
    chk("disp_commit_latency", 32'((n + 1) <= 17 && wr_ready === 1'b1), 32'd1);
    chk("held_write_ignored", 32'(light), 32'hA5);
    chk_disp("commit_edge_slot3", 8'h88, 8'hFC, 8'hFC);
    @(negedge clk);
    chk_disp("new_slot0", 8'h11, 8'hB6, 8'h60);
    repeat (4) @(negedge clk);
    chk_disp("new_slot1", 8'h22, 8'hBE, 8'hDA);
    repeat (4) @(negedge clk);
    chk_disp("new_slot2", 8'h44, 8'hE0, 8'hF2);
    repeat (4) @(negedge clk);
    chk_disp("new_slot3", 8'h88, 8'hFE, 8'h66);

    // Blank digit 0
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h0000_0101;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ctrl_ready", 32'(wr_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk_disp("blank_slot0", 8'h10, 8'hB6, 8'h00);

    // Disable display, then commit a new value while dark
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h0000_0000;
    @(negedge clk);
    wr_addr = 2'd1; wr_data = 32'h0000_00E9;
    @(negedge clk);
    wr_en = 1'b0;
    chk("dark_ready_low", 32'(wr_ready), 32'd0);
    chk_disp("dark_pending", 8'h00, 8'h00, 8'h00);
    wait_ready(40, n);
    chk("dark_commit_done", 32'(wr_ready), 32'd1);
    chk_disp("dark_after_commit", 8'h00, 8'h00, 8'h00);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h0000_0001;
    @(negedge clk);
    wr_en = 1'b0;
    wait_tub("reenable_slot0", 8'h11, 20);
    chk("reenable_seg1", 32'(seg_ctrl1), 32'hFC);
    chk("reenable_seg2", 32'(seg_ctrl2), 32'hF6);

    // Reset while pending discards the shadow value
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rst_pending_ready_low", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_async_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_disp("rst_release", 8'h11, 8'hFC, 8'hFC);
    chk("rst_release_light", 32'(light), 32'h00);
    repeat (20) @(negedge clk);
    chk("rst_no_commit_ready", 32'(wr_ready), 32'd1);
    wait_tub("rst_frame_slot0", 8'h11, 20);
    chk("rst_frame_seg1", 32'(seg_ctrl1), 32'hFC);
    chk("rst_frame_seg2", 32'(seg_ctrl2), 32'hFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
